// File: rtl/round_judge_if.sv
// Round judge bus: round request, buttons in; lamp, status and results out.
interface round_judge_if;
  logic       roundStart;
  logic       btn1;
  logic       btn2;
  logic       target;
  logic       busy;
  logic [1:0] b1;
  logic [1:0] b2;
  logic       startCalc;

  modport master (
    output roundStart, btn1, btn2,
    input  target, busy, b1, b2, startCalc
  );

  modport slave (
    input  roundStart, btn1, btn2,
    output target, busy, b1, b2, startCalc
  );
endinterface

// File: rtl/round_judge.sv
// Reaction round judge: WAIT then LIT phase, early press = miss, lit press = hit.
// Optional BTN_SYNC_EN adds a 2-flop button synchronizer (3-cycle judge latency).
module round_judge #(
  parameter int unsigned DELAY_CYCLES = 100000000,
  parameter int unsigned LIT_CYCLES   = 50000000
) (
  input logic         clk,
  input logic         rst,
  round_judge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    LIT,
    REPORT
  } state_t;

  localparam logic [31:0] DLAST = 32'(DELAY_CYCLES - 1);
  localparam logic [31:0] LLAST = 32'(LIT_CYCLES - 1);

  localparam logic [1:0] MISS   = 2'd0;
  localparam logic [1:0] HIT    = 2'd1;
  localparam logic [1:0] NOPRES = 2'd2;

  state_t      state;
  logic [31:0] cnt;
  logic [1:0]  lat;
  logic [1:0]  res [2];
  logic        tgt;
  logic        bsy;
  logic        sc;

  logic [1:0] raw;
  logic [1:0] hist;
  logic [1:0] armed;
  logic [1:0] ev;

  assign raw = {bus.btn2, bus.btn1};

`ifdef BTN_SYNC_EN
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] evq;

  // armed blocks a level held through reset from looking like a press
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      hist  <= '0;
      armed <= '0;
      evq   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      hist  <= s2;
      armed <= armed | ~s2;
      evq   <= s2 & ~hist & armed;
    end
  end

  assign ev = evq;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      hist  <= '0;
      armed <= '0;
    end else begin
      hist  <= raw;
      armed <= armed | ~raw;
    end
  end

  assign ev = raw & ~hist & armed;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      lat    <= '0;
      res[0] <= NOPRES;
      res[1] <= NOPRES;
      tgt    <= 1'b0;
      bsy    <= 1'b0;
      sc     <= 1'b0;
    end else begin
      sc <= 1'b0;
      if (state == WAIT || state == LIT) begin
        for (int i = 0; i < 2; i++) begin
          if (ev[i] && !lat[i]) begin
            lat[i] <= 1'b1;
            res[i] <= (state == LIT) ? HIT : MISS;
          end
        end
      end
      unique case (state)
        IDLE: begin
          if (bus.roundStart) begin
            state  <= WAIT;
            cnt    <= '0;
            lat    <= '0;
            res[0] <= NOPRES;
            res[1] <= NOPRES;
            bsy    <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == DLAST) begin
            state <= LIT;
            cnt   <= '0;
            tgt   <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        LIT: begin
          if (cnt == LLAST) begin
            state <= REPORT;
            cnt   <= '0;
            tgt   <= 1'b0;
            sc    <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        REPORT: begin
          state <= IDLE;
          bsy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.target    = tgt;
  assign bus.busy      = bsy;
  assign bus.startCalc = sc;
  assign bus.b1        = res[0];
  assign bus.b2        = res[1];

endmodule

// File: tb/tb_round_judge.sv
// Directed bench for round_judge, DELAY_CYCLES=4, LIT_CYCLES=6.
module tb_round_judge;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  round_judge_if bus ();

  round_judge #(
    .DELAY_CYCLES(4),
    .LIT_CYCLES  (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // mask bit i gives the button level in round cycle i-1 (bit 0 is the cycle before roundStart)
  task automatic run_round(input string tag, input logic [14:0] m1, input logic [14:0] m2,
                           input logic [1:0] e1, input logic [1:0] e2);
    for (int i = 0; i < 15; i++) begin
      int n;
      n = i - 1;
      bus.roundStart = (n == 0);
      bus.btn1 = m1[i];
      bus.btn2 = m2[i];
      chk($sformatf("%s.target@%0d", tag, n), {1'b0, bus.target},
          {1'b0, (n >= 5 && n <= 10)});
      chk($sformatf("%s.busy@%0d", tag, n), {1'b0, bus.busy},
          {1'b0, (n >= 1 && n <= 11)});
      chk($sformatf("%s.startCalc@%0d", tag, n), {1'b0, bus.startCalc},
          {1'b0, (n == 11)});
      if (n == 1) begin
        chk($sformatf("%s.b1_load", tag), bus.b1, 2'd2);
        chk($sformatf("%s.b2_load", tag), bus.b2, 2'd2);
      end
      if (n == 11) begin
        chk($sformatf("%s.b1_report", tag), bus.b1, e1);
        chk($sformatf("%s.b2_report", tag), bus.b2, e2);
      end
      step();
    end
    chk($sformatf("%s.b1_hold", tag), bus.b1, e1);
    chk($sformatf("%s.b2_hold", tag), bus.b2, e2);
  endtask

  initial begin
    rst = 1'b1;
    bus.roundStart = 1'b0;
    bus.btn1 = 1'b0;
    bus.btn2 = 1'b0;
    step();
    step();
    chk("rst.b1", bus.b1, 2'd2);
    chk("rst.b2", bus.b2, 2'd2);
    chk("rst.busy", {1'b0, bus.busy}, 2'd0);
    chk("rst.target", {1'b0, bus.target}, 2'd0);
    chk("rst.startCalc", {1'b0, bus.startCalc}, 2'd0);
    rst = 1'b0;
    step();
    step();

    run_round("nopress", 15'h0000, 15'h0000, 2'd2, 2'd2);
`ifdef BTN_SYNC_EN
    run_round("miss_hit_sync", 15'h0007, 15'h0060, 2'd0, 2'd1);
`else
    run_round("miss_hit", 15'h0038, 15'h0300, 2'd0, 2'd1);
    run_round("latch_held", 15'h0318, 15'h7fff, 2'd0, 2'd2);
    run_round("last_lit", 15'h1800, 15'h1800, 2'd1, 2'd1);
    run_round("report_cyc", 15'h3000, 15'h3000, 2'd2, 2'd2);
`endif

    for (int n = 0; n < 8; n++) begin
      bus.roundStart = (n == 0 || n == 3);
      bus.btn1 = (n == 2) || (n >= 5);
      bus.btn2 = 1'b0;
      rst = (n == 6);
      chk($sformatf("abort.startCalc@%0d", n), {1'b0, bus.startCalc}, 2'd0);
      if (n == 6) chk("abort.b1_pre", bus.b1, 2'd0);
      if (n == 7) begin
        chk("abort.busy", {1'b0, bus.busy}, 2'd0);
        chk("abort.target", {1'b0, bus.target}, 2'd0);
        chk("abort.b1", bus.b1, 2'd2);
        chk("abort.b2", bus.b2, 2'd2);
      end
      step();
    end
    rst = 1'b0;
    run_round("held_thru_rst", 15'h000f, 15'h0000, 2'd2, 2'd2);
    run_round("fresh", 15'h0000, 15'h0000, 2'd2, 2'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
